ram_dump_reader: RTL and testbench

Sequential read-out engine for the SoC's synchronous data RAM: on a start pulse it reads a contiguous range of words and streams each word, tagged with its address, over a valid/ready interface. It is the read-side counterpart of the memory preload path, used by benches and debug logic to pull final memory contents out of the SoC for comparison against expected images. It sits beside the data RAM on a spare read port and never writes memory.

---
 rtl/ram_dump_reader.sv | 122 ++++++++++++
 tb/tb_ram_dump_reader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dump_reader.sv
// Streams a contiguous range of data-RAM words, tagged with their addresses, over valid/ready.
// Optional running checksum of transferred words: define RAM_DUMP_CHECKSUM_EN.
module ram_dump_reader #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   word_count,
   output logic                  busy,
   output logic                  done,
   output logic                  ram_re,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   input  logic [DATA_WIDTH-1:0] ram_rdata,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic [DATA_WIDTH-1:0] checksum
);

   localparam int unsigned CNT_W = ADDR_WIDTH + 1;

   typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, DONE} state_t;

   state_t                  state, state_d;
   logic [ADDR_WIDTH-1:0]   addr, addr_d;
   logic [CNT_W-1:0]        rem, rem_d;
   logic                    out_valid_d;
   logic [DATA_WIDTH-1:0]   out_data_d;
   logic [ADDR_WIDTH-1:0]   out_addr_d;
   logic [ADDR_WIDTH-1:0]   ram_addr_d;
`ifdef RAM_DUMP_CHECKSUM_EN
   logic [DATA_WIDTH-1:0]   csum, csum_d;
`endif

   // Next-state and datapath updates; control outputs are registered from the next state.
   always_comb begin
      state_d     = state;
      addr_d      = addr;
      rem_d       = rem;
      out_valid_d = out_valid;
      out_data_d  = out_data;
      out_addr_d  = out_addr;
`ifdef RAM_DUMP_CHECKSUM_EN
      csum_d      = csum;
`endif
      unique case (state)
         IDLE: begin
            if (start) begin
               addr_d  = base_addr;
               rem_d   = word_count;
`ifdef RAM_DUMP_CHECKSUM_EN
               csum_d  = '0;
`endif
               state_d = (word_count == '0) ? DONE : READ;
            end
         end
         READ: state_d = WAIT;
         WAIT: begin
            out_valid_d = 1'b1;
            out_data_d  = ram_rdata;
            out_addr_d  = addr;
            state_d     = SEND;
         end
         SEND: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               rem_d       = rem - CNT_W'(1);
               addr_d      = addr + ADDR_WIDTH'(1);
`ifdef RAM_DUMP_CHECKSUM_EN
               csum_d      = csum + out_data;
`endif
               state_d     = (rem == CNT_W'(1)) ? DONE : READ;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // ram_addr only moves when a read is being issued
      ram_addr_d = (state_d == READ) ? addr_d : ram_addr;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         addr      <= '0;
         rem       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         ram_re    <= 1'b0;
         ram_addr  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_addr  <= '0;
      end else begin
         state     <= state_d;
         addr      <= addr_d;
         rem       <= rem_d;
         busy      <= (state_d != IDLE);
         done      <= (state_d == DONE);
         ram_re    <= (state_d == READ);
         ram_addr  <= ram_addr_d;
         out_valid <= out_valid_d;
         out_data  <= out_data_d;
         out_addr  <= out_addr_d;
      end
   end

`ifdef RAM_DUMP_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) csum <= '0;
      else      csum <= csum_d;
   end
   assign checksum = csum;
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_ram_dump_reader.sv
// Self-checking bench for ram_dump_reader: table of dumps plus random dumps against a queue model.
// Honours RAM_DUMP_CHECKSUM_EN for the expected checksum.
module tb_ram_dump_reader;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [9:0]  base_addr = '0;
   logic [10:0] word_count = '0;
   logic        busy, done, ram_re, out_valid;
   logic        out_ready = 1'b0;
   logic [9:0]  ram_addr, out_addr;
   logic [31:0] ram_rdata = '0;
   logic [31:0] out_data, checksum;

   logic [31:0] mem [1024];
   int checks = 0;
   int errors = 0;

   ram_dump_reader dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
      .busy(busy), .done(done), .ram_re(ram_re), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
      .checksum(checksum)
   );

   always #5 clk = ~clk;

   // Synchronous RAM: data valid the cycle after ram_re, garbage otherwise
   always @(posedge clk) begin
      if (ram_re) ram_rdata <= mem[ram_addr];
      else        ram_rdata <= $urandom;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, ".busy"}, 64'(busy), 64'd0);
      chk({tag, ".done"}, 64'(done), 64'd0);
      chk({tag, ".ram_re"}, 64'(ram_re), 64'd0);
      chk({tag, ".ram_addr"}, 64'(ram_addr), 64'd0);
      chk({tag, ".out_valid"}, 64'(out_valid), 64'd0);
      chk({tag, ".out_data"}, 64'(out_data), 64'd0);
      chk({tag, ".out_addr"}, 64'(out_addr), 64'd0);
      chk({tag, ".checksum"}, 64'(checksum), 64'd0);
   endtask

   // mode 0: ready always, 1: ready one cycle in three, 2: random ready
   // poke: stray starts during the dump and during DONE, both must be ignored
   task automatic run_dump(input logic [9:0] base, input logic [10:0] cnt, input int mode,
                           input bit poke, input logic [9:0] exp_last, input string tag);
      logic [9:0]  exp_a [$];
      logic [31:0] exp_d [$];
      logic [31:0] sum = '0;
      logic [31:0] exp_cs;
      logic [31:0] prev_d = '0;
      logic [9:0]  prev_a = '0;
      logic [9:0]  last_a = '0;
      bit          prev_stall = 1'b0;
      bit          r;
      int cyc, first_v = -1, last_hs = -1, done_cyc = -1, nre = 0, nbusy = 0, nhs = 0;

      for (int i = 0; i < int'(cnt); i++) begin
         logic [9:0] a;
         a = 10'((int'(base) + i) % 1024);
         exp_a.push_back(a);
         exp_d.push_back(mem[a]);
         sum = sum + mem[a];
      end
`ifdef RAM_DUMP_CHECKSUM_EN
      exp_cs = sum;
`else
      exp_cs = '0;
`endif

      start = 1'b1; base_addr = base; word_count = cnt; out_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0; base_addr = 10'($urandom); word_count = 11'($urandom);
      cyc = 1;
      while (cyc < 20000) begin
         start = 1'b0;
         if (busy) nbusy++;
         if (ram_re) begin
            chk({tag, ".ram_addr"}, 64'(ram_addr), 64'(10'(base + 10'(nre))));
            nre++;
         end
         if (out_valid && first_v < 0) first_v = cyc;
         if (prev_stall) begin
            chk({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
            chk({tag, ".hold_data"}, 64'(out_data), 64'(prev_d));
            chk({tag, ".hold_addr"}, 64'(out_addr), 64'(prev_a));
         end
         if (done) begin
            done_cyc = cyc;
            chk({tag, ".checksum"}, 64'(checksum), 64'(exp_cs));
            if (poke) begin
               start = 1'b1; base_addr = base ^ 10'h0AA; word_count = 11'd3;
            end
            break;
         end
         case (mode)
            0: r = 1'b1;
            1: r = (cyc % 3 == 0);
            default: r = 1'($urandom);
         endcase
         out_ready = r;
         if (out_valid && r) begin
            if (exp_a.size() == 0) begin
               chk({tag, ".extra_word"}, 64'(out_addr), 64'hDEAD);
            end else begin
               chk({tag, ".out_addr"}, 64'(out_addr), 64'(exp_a.pop_front()));
               chk({tag, ".out_data"}, 64'(out_data), 64'(exp_d.pop_front()));
            end
            last_a = out_addr;
            last_hs = cyc;
            nhs++;
         end
         prev_stall = out_valid && !r;
         prev_d = out_data;
         prev_a = out_addr;
         if (poke && cyc == 4) begin
            start = 1'b1; base_addr = base ^ 10'h155; word_count = 11'd7;
         end
         @(posedge clk); #1;
         cyc++;
      end
      out_ready = 1'b0;
      if (done_cyc < 0) chk({tag, ".timeout"}, 64'd0, 64'd1);

      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, ".idle_busy"}, 64'(busy), 64'd0);
      chk({tag, ".single_done"}, 64'(done), 64'd0);
      chk({tag, ".idle_ram_re"}, 64'(ram_re), 64'd0);
      chk({tag, ".checksum_hold"}, 64'(checksum), 64'(exp_cs));
      chk({tag, ".words"}, 64'(nhs), 64'(cnt));
      chk({tag, ".reads"}, 64'(nre), 64'(cnt));
      chk({tag, ".busy_cycles"}, 64'(nbusy), 64'(done_cyc));
      if (cnt == '0) begin
         chk({tag, ".first_valid"}, 64'(first_v), 64'(-1));
         chk({tag, ".done_cycle"}, 64'(done_cyc), 64'd1);
      end else begin
         chk({tag, ".first_valid"}, 64'(first_v), 64'd3);
         chk({tag, ".done_cycle"}, 64'(done_cyc), 64'(last_hs + 1));
         chk({tag, ".last_addr"}, 64'(last_a), 64'(exp_last));
      end
   endtask

   typedef struct {
      logic [9:0]  base;
      logic [10:0] cnt;
      int          mode;
      bit          poke;
      logic [9:0]  exp_last;
   } vec_t;

   vec_t vecs [7];

   initial begin
      vecs[0] = '{10'h010, 11'd4,     0, 1'b0, 10'h013};
      vecs[1] = '{10'h010, 11'd4,     1, 1'b0, 10'h013};
      vecs[2] = '{10'h3FE, 11'd3,     0, 1'b0, 10'h000};
      vecs[3] = '{10'h020, 11'd0,     0, 1'b0, 10'h000};
      vecs[4] = '{10'h3FF, 11'd1,     2, 1'b0, 10'h3FF};
      vecs[5] = '{10'h010, 11'd4,     0, 1'b1, 10'h013};
      vecs[6] = '{10'h100, 11'h400,   2, 1'b0, 10'h0FF};

      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      mem[16'h10] = 32'h11; mem[16'h11] = 32'h22; mem[16'h12] = 32'h33; mem[16'h13] = 32'h44;

      #12;
      chk_reset_outputs("reset");
      rst = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) begin
         run_dump(vecs[i].base, vecs[i].cnt, vecs[i].mode, vecs[i].poke, vecs[i].exp_last,
                  $sformatf("vec%0d", i));
      end

      // Known-image checksum for the preloaded words
      run_dump(10'h010, 11'd4, 0, 1'b0, 10'h013, "preload");
`ifdef RAM_DUMP_CHECKSUM_EN
      chk("preload.checksum_abs", 64'(checksum), 64'hAA);
`else
      chk("preload.checksum_abs", 64'(checksum), 64'h0);
`endif

      // Abort with reset during SEND of the second of four words
      begin
         int hs = 0;
         int n = 0;
         bit hit = 1'b0;
         start = 1'b1; base_addr = 10'h040; word_count = 11'd4;
         @(posedge clk); #1;
         start = 1'b0;
         while (n < 50) begin
            if (out_valid && hs == 1) begin
               hit = 1'b1;
               break;
            end
            out_ready = (out_valid && hs == 0);
            if (out_valid && out_ready) hs++;
            @(posedge clk); #1;
            n++;
         end
         out_ready = 1'b0;
         chk("abort.reached_send2", 64'(hit), 64'd1);
         #2 rst = 1'b0;
         #1;
         chk_reset_outputs("abort");
         for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("abort.no_done", 64'(done), 64'd0);
         end
         rst = 1'b1;
         @(posedge clk); #1;
         chk("abort.idle_after", 64'(busy), 64'd0);
      end
      run_dump(10'h200, 11'd5, 2, 1'b0, 10'h204, "after_abort");

      for (int i = 0; i < 6; i++) begin
         logic [9:0]  b;
         logic [10:0] c;
         b = 10'($urandom);
         c = 11'($urandom_range(0, 40));
         run_dump(b, c, 2, 1'($urandom), 10'(b + 10'(c) - 10'd1), $sformatf("rand%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
